// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode types for the 5-stage core: default widths, the bubble
// instruction and the {instr, pc} entry held by the IF/ID queue.
package core_pkg;

   localparam int unsigned      XLEN_DEFAULT      = 32;
   localparam logic [31:0]      NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] instr;
      logic [XLEN_DEFAULT-1:0] pc;
   } fd_entry_t;

   // An all-zero word is an illegal encoding, so it becomes a bubble instead.
   function automatic logic [XLEN_DEFAULT-1:0] zero_filter(
      input logic [XLEN_DEFAULT-1:0] instr,
      input logic [XLEN_DEFAULT-1:0] nop
   );
      return (instr == '0) ? nop : instr;
   endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between fetch (master) and the IF/ID queue (slave), with
// decode's pop side and the pipeline flush carried alongside.
interface if_id_queue_if #(
   parameter int unsigned XLEN  = core_pkg::XLEN_DEFAULT,
   parameter int unsigned DEPTH = 2
);
   logic                         flush;
   logic                         in_valid;
   logic                         in_ready;
   logic [XLEN-1:0]              instr_in;
   logic [XLEN-1:0]              pc_in;
   logic                         out_valid;
   logic                         out_ready;
   logic [XLEN-1:0]              instr_out;
   logic [XLEN-1:0]              pc_out;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output flush, in_valid, instr_in, pc_in, out_ready,
      input  in_ready, out_valid, instr_out, pc_out, count
   );

   modport slave (
      input  flush, in_valid, instr_in, pc_in, out_ready,
      output in_ready, out_valid, instr_out, pc_out, count
   );

endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction FIFO with flush and zero-word NOP substitution.
// Define IF_ID_QUEUE_BYPASS_EN for a same-cycle path through an empty queue.
module if_id_queue
   import core_pkg::*;
#(
   parameter int unsigned     XLEN      = XLEN_DEFAULT,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input logic            clk,
   input logic            reset_n,
   if_id_queue_if.slave   bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   fd_entry_t       storage [DEPTH];
   fd_entry_t       head;
   fd_entry_t       incoming;
   logic [PW-1:0]   wrPtr_q, wrPtr_d;
   logic [PW-1:0]   rdPtr_q, rdPtr_d;
   logic            empty;
   logic            full;
   logic            bypass;
   logic            doPush;
   logic            doPop;

   assign empty = (wrPtr_q == rdPtr_q);
   assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

   assign head           = storage[rdPtr_q[AW-1:0]];
   assign incoming.instr = zero_filter(bus.instr_in, NOP_INSTR);
   assign incoming.pc    = bus.pc_in;

`ifdef IF_ID_QUEUE_BYPASS_EN
   assign bypass = empty && bus.in_valid && !bus.flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry taken by decode in the same cycle never touches storage.
   assign doPush = bus.in_valid && !full && !bus.flush && !(bypass && bus.out_ready);
   assign doPop  = !empty && bus.out_ready && !bus.flush;

   assign bus.in_ready  = !full;
   assign bus.count     = wrPtr_q - rdPtr_q;
   assign bus.out_valid = !empty || bypass;
   assign bus.instr_out = bypass ? incoming.instr : (!empty ? head.instr : NOP_INSTR);
   assign bus.pc_out    = bypass ? incoming.pc    : (!empty ? head.pc    : '0);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (bus.flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
      end else begin
         if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
         end
         if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Entry contents need no reset: outputs are masked whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (doPush) begin
         storage[wrPtr_q[AW-1:0]] <= incoming;
      end
   end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID boundary buffer that replaces the single-entry fetch/decode register with a DEPTH-entry instruction FIFO using valid/ready handshakes. Fetch pushes {instruction, PC} pairs and decode pops them. The block adds a synchronous pipeline flush and NOP substitution for all-zero instruction words. Optionally, a zero-latency bypass path is available when the queue is empty. It sits between the fetch unit and the decoder of the 5-stage core.

## Interface
- XLEN, 32, width of instruction and PC fields
- DEPTH, 2, number of entries; power of two, ≥ 2
- NOP_INSTR, 32'h00000013, bubble value (`addi x0,x0,0`) presented when nothing valid is at the output
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries and any same-cycle push
- in_valid  in  1  fetch offers instr_in/pc_in
- in_ready  out  1  queue accepts the offer; equals !full
- instr_in  in  XLEN  fetched instruction
- pc_in  in  XLEN  PC of instr_in
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes the head this cycle
- instr_out  out  XLEN  head instruction, or NOP_INSTR when !out_valid
- pc_out  out  XLEN  head PC, or 0 when !out_valid
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH×(2·XLEN) register array. Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. empty = ptrs equal. full = MSBs differ and LSBs equal.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Simultaneous push and pop:
  - Both pointers advance.
  - count is unchanged.
  - Only possible when the queue is not full, because in_ready does not look at out_ready.
- Zero filter: a pushed instr_in == 0 is stored as NOP_INSTR with its pc_in kept. The entry still counts as a valid entry.
- Flush:
  - Both pointers return to 0 and count goes to 0 on the next edge.
  - Any same-cycle push or pop is ignored.
  - flush wins over everything except reset.
- Output mux:
  - When out_valid=1, instr_out and pc_out show the head entry.
  - Otherwise they show NOP_INSTR and 0.
- There is no state machine beyond the pointer pair. Occupancy states are EMPTY, PARTIAL and FULL:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at count=DEPTH−1.
  - FULL→PARTIAL on pop.
  - any→EMPTY on flush.
- Reset mid-operation: the contents are abandoned immediately, without waiting for a clock edge.

## Timing
- Reset values:
  - count=0, out_valid=0, in_ready=1
  - instr_out=NOP_INSTR, pc_out=0
  - pointers=0
- Latency without bypass: a push at edge N makes out_valid=1 after edge N, so the entry is visible in cycle N+1.
- in_ready, out_valid, instr_out, pc_out and count are combinational from registered state only, except in the bypass path.
- Throughput: 1 entry per cycle sustained with DEPTH ≥ 2.
- After a flush edge: out_valid=0 and in_ready=1 in the following cycle.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined:
  - When empty && in_valid && !flush, the outputs pass instr_in (zero-filtered) and pc_in straight through, and out_valid=1 in the same cycle.
  - If out_ready is also high, the entry is consumed without being written into storage, and the pointers stay put.
  - If out_ready is low, the entry is written as a normal push.
- IF_ID_QUEUE_BYPASS_EN undefined:
  - Strictly registered.
  - Minimum latency of 1 cycle.
  - No combinational path from in_* to out_*.

## Structure
- Shared package core_pkg holds:
  - NOP_INSTR_DEFAULT (32'h00000013)
  - XLEN_DEFAULT
  - the packed typedef fd_entry_t {instr, pc}, used for the storage array
- No sub-module is needed. Pointer/full/empty logic is inline; a separate FIFO primitive would obscure the zero-filter and flush priority.

## Test plan
- Reset check: assert reset_n=0 mid-clock with 2 entries held → the same instant, out_valid=0, count=0, instr_out=32'h00000013, in_ready=1.
- Fill and overflow hold-off, DEPTH=2, out_ready=0:
  - Push PC 0x00/0x04 with instrs 0x00500093 and 0x00A00113 → count=2, in_ready=0.
  - A third offer (PC 0x08) is not accepted and is not stored.
- Ordering and simultaneous push/pop:
  - Stream 8 instrs at PC 0x00..0x1C with out_ready=1 continuously → decode sees them in order, 1 per cycle, and count stays at 1.
- Zero filter: push instr 32'h00000000 at PC 0x40 → pops as instr 0x00000013 with pc 0x40 and out_valid=1.
- Flush priority: with 2 entries, in the same cycle assert flush, in_valid (PC 0x80) and out_ready → next cycle count=0, out_valid=0, and PC 0x80 is never observed.
- Bypass, with IF_ID_QUEUE_BYPASS_EN defined:
  - Empty queue, push 0x00500093 at PC 0x100 with out_ready=1 → out_valid=1 in the same cycle and count stays 0.
  - Without the macro, the same stimulus gives out_valid=1 one cycle later.
